// File: rtl/patch_mac_endpoint.sv
`default_nettype none
// ============================================================================
// Module   : patch_mac_endpoint
// Purpose  : Xillybus 32-bit stream endpoint. Loads a kernel, takes the dot
//            product of each patch with it in a 3-stage MAC pipeline and
//            queues one Q-format result per patch on the read stream.
// Options  : PATCH_MAC_SATURATE_EN - saturate (rather than wrap) the result
//            when it is narrowed to 32 bits.
// Revision : 1.0 - initial release
// ============================================================================
module patch_mac_endpoint #(
    parameter int KLEN      = 9,
    parameter int FRAC_BITS = 16,
    parameter int OUT_DEPTH = 16
) (
    input  logic        bus_clk,
    input  logic        bus_rst_n,
    input  logic [31:0] user_w_write_kernel_32_data,
    input  logic        user_w_write_kernel_32_wren,
    output logic        user_w_write_kernel_32_full,
    input  logic        user_w_write_kernel_32_open,
    input  logic [31:0] user_w_write_patch_32_data,
    input  logic        user_w_write_patch_32_wren,
    output logic        user_w_write_patch_32_full,
    input  logic        user_w_write_patch_32_open,
    input  logic        user_r_read_32_rden,
    output logic [31:0] user_r_read_32_data,
    output logic        user_r_read_32_empty,
    output logic        user_r_read_32_eof,
    input  logic        user_r_read_32_open
);

    localparam int              c_kw    = $clog2(KLEN);
    localparam int              c_aw    = $clog2(OUT_DEPTH);
    localparam logic [c_kw-1:0] c_klast = c_kw'(KLEN - 1);
    localparam logic [c_aw:0]   c_depth = (c_aw + 1)'(OUT_DEPTH);

    logic [31:0]        r_kram [KLEN];
    logic [c_kw-1:0]    r_kidx;
    logic [c_kw-1:0]    r_pidx;
    logic               r_kloaded;

    logic               r_s1_v, r_s1_first, r_s1_last;
    logic [31:0]        r_s1_p, r_s1_k;
    logic               r_s2_v, r_s2_first, r_s2_last;
    logic signed [63:0] r_s2_prod;
    logic               r_s3_v, r_s3_last;
    logic signed [71:0] r_acc;

    logic [31:0]        r_fifo [OUT_DEPTH];
    logic [c_aw-1:0]    r_wr_ptr, r_rd_ptr;
    logic [c_aw:0]      r_count;
    logic [c_aw:0]      r_reserved;
    logic [31:0]        r_rd_data;
    logic               r_eof;
    logic               r_patch_open_d;
    logic               r_read_open_d;

    logic               w_pipe_busy;
    logic               w_kernel_full;
    logic               w_patch_full;
    logic               w_abort;
    logic               w_flush;
    logic               w_open_rise;
    logic               w_k_acc;
    logic               w_p_acc;
    logic               w_p_last;
    logic               w_push;
    logic               w_pop;
    logic               w_empty;
    logic               w_keep_s1;
    logic               w_keep_s2;
    logic               w_eof_cond;
    logic signed [63:0] w_pa, w_pb, w_prod;
    logic signed [71:0] w_prod_ext;
    logic [31:0]        w_result;
    logic [c_aw:0]      w_res_inc, w_res_dec;

    assign w_pipe_busy   = r_s1_v | r_s2_v | r_s3_v;
    assign w_kernel_full = (r_pidx != '0) || w_pipe_busy;
    assign w_patch_full  = !r_kloaded || (r_reserved == c_depth);
    assign w_abort       = r_patch_open_d && !user_w_write_patch_32_open;
    assign w_open_rise   = !r_patch_open_d && user_w_write_patch_32_open;
    assign w_flush       = r_read_open_d && !user_r_read_32_open;

    assign w_k_acc  = user_w_write_kernel_32_wren && user_w_write_kernel_32_open && !w_kernel_full;
    assign w_p_acc  = user_w_write_patch_32_wren && !w_patch_full && !w_abort;
    assign w_p_last = (r_pidx == c_klast);

    assign w_push  = r_s3_v && r_s3_last;
    assign w_empty = (r_count == '0) || r_eof;
    assign w_pop   = user_r_read_32_rden && !w_empty && !w_flush;

    // On abort, only words younger than the newest in-flight 'last' belong to
    // the partial patch; older words complete an already-reserved result.
    assign w_keep_s1 = !w_abort || r_s1_last;
    assign w_keep_s2 = !w_abort || r_s2_last || (r_s1_v && r_s1_last);

    assign w_eof_cond = !user_w_write_patch_32_open && (r_pidx == '0) &&
                        !w_pipe_busy && (r_count == '0);

    assign w_pa       = {{32{r_s1_p[31]}}, r_s1_p};
    assign w_pb       = {{32{r_s1_k[31]}}, r_s1_k};
    assign w_prod     = w_pa * w_pb;
    assign w_prod_ext = {{8{r_s2_prod[63]}}, r_s2_prod};

`ifdef PATCH_MAC_SATURATE_EN
    logic signed [71:0] w_shift;
    logic               w_ovf;
    assign w_shift  = r_acc >>> FRAC_BITS;
    assign w_ovf    = !((&w_shift[71:31]) || !(|w_shift[71:31]));
    assign w_result = w_ovf ? (w_shift[71] ? 32'h8000_0000 : 32'h7FFF_FFFF)
                            : w_shift[31:0];
`else
    assign w_result = 32'(r_acc >>> FRAC_BITS);
`endif

    assign w_res_inc = (c_aw + 1)'(w_p_acc && w_p_last);
    assign w_res_dec = w_flush ? r_count : (c_aw + 1)'(w_pop);

    // Storage arrays carry no reset; their contents are qualified by indices.
    always_ff @(posedge bus_clk) begin
        if (w_k_acc) begin
            r_kram[r_kidx] <= user_w_write_kernel_32_data;
        end
        if (w_push) begin
            r_fifo[r_wr_ptr] <= w_result;
        end
    end

    always_ff @(posedge bus_clk or negedge bus_rst_n) begin
        if (!bus_rst_n) begin
            r_kidx         <= '0;
            r_kloaded      <= 1'b0;
            r_pidx         <= '0;
            r_patch_open_d <= 1'b0;
            r_read_open_d  <= 1'b0;
        end else begin
            r_patch_open_d <= user_w_write_patch_32_open;
            r_read_open_d  <= user_r_read_32_open;
            if (w_k_acc) begin
                if (r_kidx == c_klast) begin
                    r_kidx    <= '0;
                    r_kloaded <= 1'b1;
                end else begin
                    r_kidx <= r_kidx + 1'b1;
                end
            end
            if (w_abort) begin
                r_pidx <= '0;
            end else if (w_p_acc) begin
                r_pidx <= w_p_last ? '0 : r_pidx + 1'b1;
            end
        end
    end

    always_ff @(posedge bus_clk or negedge bus_rst_n) begin
        if (!bus_rst_n) begin
            r_s1_v     <= 1'b0;
            r_s1_first <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_p     <= '0;
            r_s1_k     <= '0;
            r_s2_v     <= 1'b0;
            r_s2_first <= 1'b0;
            r_s2_last  <= 1'b0;
            r_s2_prod  <= '0;
            r_s3_v     <= 1'b0;
            r_s3_last  <= 1'b0;
            r_acc      <= '0;
        end else begin
            r_s1_v <= w_p_acc;
            if (w_p_acc) begin
                r_s1_p     <= user_w_write_patch_32_data;
                r_s1_k     <= r_kram[r_pidx];
                r_s1_first <= (r_pidx == '0);
                r_s1_last  <= w_p_last;
            end

            r_s2_v <= r_s1_v && w_keep_s1;
            if (r_s1_v) begin
                r_s2_prod  <= w_prod;
                r_s2_first <= r_s1_first;
                r_s2_last  <= r_s1_last;
            end

            r_s3_v <= r_s2_v && w_keep_s2;
            if (r_s2_v && w_keep_s2) begin
                r_acc     <= r_s2_first ? w_prod_ext : r_acc + w_prod_ext;
                r_s3_last <= r_s2_last;
            end
        end
    end

    always_ff @(posedge bus_clk or negedge bus_rst_n) begin
        if (!bus_rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_reserved <= '0;
            r_rd_data  <= '0;
            r_eof      <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            // A flush drops everything queued; a same-cycle push survives it.
            if (w_flush) begin
                r_rd_ptr <= r_wr_ptr;
                r_count  <= (c_aw + 1)'(w_push);
            end else begin
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
                r_count <= r_count + (c_aw + 1)'(w_push) - (c_aw + 1)'(w_pop);
            end
            if (w_pop) begin
                r_rd_data <= r_fifo[r_rd_ptr];
            end
            r_reserved <= r_reserved + w_res_inc - w_res_dec;

            if (w_open_rise) begin
                r_eof <= 1'b0;
            end else if (w_eof_cond) begin
                r_eof <= 1'b1;
            end
        end
    end

    assign user_w_write_kernel_32_full = w_kernel_full;
    assign user_w_write_patch_32_full  = w_patch_full;
    assign user_r_read_32_data         = r_rd_data;
    assign user_r_read_32_empty        = w_empty;
    assign user_r_read_32_eof          = r_eof;

endmodule
`default_nettype wire

// File: tb/tb_patch_mac_endpoint.sv
`default_nettype none
// ============================================================================
// Module   : tb_patch_mac_endpoint
// Purpose  : Directed self-checking bench for patch_mac_endpoint (KLEN=9,
//            FRAC_BITS=16, OUT_DEPTH=16).
// Revision : 1.0 - initial release
// ============================================================================
module tb_patch_mac_endpoint;

    logic        clk;
    logic        rst_n;
    logic [31:0] kdata;
    logic        kwren;
    logic        kfull;
    logic        kopen;
    logic [31:0] pdata;
    logic        pwren;
    logic        pfull;
    logic        popen;
    logic        rden;
    logic [31:0] rdata;
    logic        empty;
    logic        eof;
    logic        ropen;

    int n_tests = 0;
    int n_fail  = 0;

    patch_mac_endpoint dut (
        .bus_clk                     (clk),
        .bus_rst_n                   (rst_n),
        .user_w_write_kernel_32_data (kdata),
        .user_w_write_kernel_32_wren (kwren),
        .user_w_write_kernel_32_full (kfull),
        .user_w_write_kernel_32_open (kopen),
        .user_w_write_patch_32_data  (pdata),
        .user_w_write_patch_32_wren  (pwren),
        .user_w_write_patch_32_full  (pfull),
        .user_w_write_patch_32_open  (popen),
        .user_r_read_32_rden         (rden),
        .user_r_read_32_data         (rdata),
        .user_r_read_32_empty        (empty),
        .user_r_read_32_eof          (eof),
        .user_r_read_32_open         (ropen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic load_kernel_const(input logic [31:0] v);
        for (int i = 0; i < 9; i++) begin
            kdata = v;
            kwren = 1'b1;
            tick();
        end
        kwren = 1'b0;
    endtask

    task automatic write_patch(input logic [31:0] base, input logic [31:0] step);
        for (int i = 0; i < 9; i++) begin
            pdata = base + 32'(i) * step;
            pwren = 1'b1;
            tick();
        end
        pwren = 1'b0;
    endtask

    task automatic do_pop(output logic [31:0] d);
        rden = 1'b1;
        tick();
        rden = 1'b0;
        d = rdata;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        n_tests++; if (kfull !== 1'b0) begin n_fail++; $display("FAIL reset_kernel_full got %b want 0", kfull); end
        n_tests++; if (pfull !== 1'b1) begin n_fail++; $display("FAIL reset_patch_full got %b want 1", pfull); end
        n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %b want 1", empty); end
        n_tests++; if (eof !== 1'b0) begin n_fail++; $display("FAIL reset_eof got %b want 0", eof); end
        n_tests++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL reset_data got %h want 00000000", rdata); end
        rst_n = 1'b1;
        repeat (2) tick();
        n_tests++; if (eof !== 1'b0) begin n_fail++; $display("FAIL reset_eof_open got %b want 0", eof); end
    endtask

    task automatic test_basic();
        logic [31:0] d;
        load_kernel_const(32'h0001_0000);
        n_tests++; if (pfull !== 1'b0) begin n_fail++; $display("FAIL basic_kloaded_full got %b want 0", pfull); end
        write_patch(32'h0001_0000, 32'h0001_0000);
        tick(); tick();
        n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL basic_empty_T2 got %b want 1", empty); end
        tick();
        n_tests++; if (empty !== 1'b0) begin n_fail++; $display("FAIL basic_empty_T3 got %b want 0", empty); end
        do_pop(d);
        n_tests++; if (d !== 32'h002D_0000) begin n_fail++; $display("FAIL basic_result got %h want 002d0000", d); end
        n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL basic_empty_after got %b want 1", empty); end
    endtask

    task automatic test_backpressure();
        logic [31:0] d;
        logic [31:0] exp_d;
        reset_dut();
        n_tests++; if (pfull !== 1'b1) begin n_fail++; $display("FAIL bp_nokernel_full got %b want 1", pfull); end
        write_patch(32'h0005_0000, 32'h0);
        repeat (4) tick();
        n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL bp_nokernel_empty got %b want 1", empty); end
        load_kernel_const(32'h0001_0000);
        for (int n = 0; n < 16; n++) begin
            write_patch(32'(n + 1) << 16, 32'h0);
        end
        n_tests++; if (pfull !== 1'b1) begin n_fail++; $display("FAIL bp_full_16 got %b want 1", pfull); end
        pdata = 32'h0011_0000;
        pwren = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++; if (pfull !== 1'b1) begin n_fail++; $display("FAIL bp_hold_full[%0d] got %b want 1", i, pfull); end
        end
        rden = 1'b1;
        tick();
        rden  = 1'b0;
        pwren = 1'b0;
        n_tests++; if (pfull !== 1'b0) begin n_fail++; $display("FAIL bp_full_after_pop got %b want 0", pfull); end
        n_tests++; if (rdata !== 32'h0009_0000) begin n_fail++; $display("FAIL bp_pop0 got %h want 00090000", rdata); end
        write_patch(32'h0011_0000, 32'h0);
        for (int n = 1; n < 17; n++) begin
            do_pop(d);
            exp_d = 32'(9 * (n + 1)) << 16;
            n_tests++; if (d !== exp_d) begin n_fail++; $display("FAIL bp_pop[%0d] got %h want %h", n, d, exp_d); end
        end
        n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL bp_drained_empty got %b want 1", empty); end
    endtask

    task automatic test_overflow();
        logic [31:0] d;
        logic [31:0] exp_d;
`ifdef PATCH_MAC_SATURATE_EN
        exp_d = 32'h7FFF_FFFF;
`else
        exp_d = 32'hFFF7_0000;
`endif
        reset_dut();
        load_kernel_const(32'h7FFF_FFFF);
        write_patch(32'h7FFF_FFFF, 32'h0);
        repeat (3) tick();
        do_pop(d);
        n_tests++; if (d !== exp_d) begin n_fail++; $display("FAIL overflow got %h want %h", d, exp_d); end
    endtask

    task automatic test_abort_eof();
        logic [31:0] d;
        load_kernel_const(32'h0001_0000);
        write_patch(32'h0001_0000, 32'h0001_0000);
        repeat (3) tick();
        for (int i = 0; i < 4; i++) begin
            pdata = 32'h0001_0000;
            pwren = 1'b1;
            tick();
        end
        pwren = 1'b0;
        popen = 1'b0;
        repeat (5) tick();
        n_tests++; if (kfull !== 1'b0) begin n_fail++; $display("FAIL abort_pidx_clear got kfull=%b want 0", kfull); end
        n_tests++; if (eof !== 1'b0) begin n_fail++; $display("FAIL abort_eof_pending got %b want 0", eof); end
        n_tests++; if (empty !== 1'b0) begin n_fail++; $display("FAIL abort_empty_pending got %b want 0", empty); end
        do_pop(d);
        n_tests++; if (d !== 32'h002D_0000) begin n_fail++; $display("FAIL abort_prev_result got %h want 002d0000", d); end
        repeat (2) tick();
        n_tests++; if (eof !== 1'b1) begin n_fail++; $display("FAIL abort_eof_set got %b want 1", eof); end
        n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL abort_eof_empty got %b want 1", empty); end
        popen = 1'b1;
        tick();
        n_tests++; if (eof !== 1'b0) begin n_fail++; $display("FAIL abort_eof_clear got %b want 0", eof); end
        n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL abort_no_result got empty=%b want 1", empty); end
        write_patch(32'h0001_0000, 32'h0001_0000);
        repeat (3) tick();
        do_pop(d);
        n_tests++; if (d !== 32'h002D_0000) begin n_fail++; $display("FAIL abort_realign got %h want 002d0000", d); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_c [4];
        logic        pre;
        int          npop;
        exp_c[0] = 32'h001B_0000;
        exp_c[1] = 32'h0024_0000;
        exp_c[2] = 32'h002D_0000;
        exp_c[3] = 32'h0036_0000;
        npop = 0;
        for (int c = 0; c < 46; c++) begin
            pwren = (c < 36);
            pdata = 32'((c / 9) + 3) << 16;
            kwren = (c >= 1 && c < 36);
            kdata = 32'h0;
            rden  = (c >= 28);
            pre   = !empty;
            tick();
            if (rden && pre) begin
                n_tests++;
                if (npop > 3) begin
                    n_fail++; $display("FAIL b2b_extra_pop got %h want none", rdata);
                end else if (rdata !== exp_c[npop]) begin
                    n_fail++; $display("FAIL b2b_pop[%0d] got %h want %h", npop, rdata, exp_c[npop]);
                end
                npop++;
            end
            if (c >= 1 && c < 36) begin
                n_tests++; if (kfull !== 1'b1) begin n_fail++; $display("FAIL b2b_kernel_full[%0d] got %b want 1", c, kfull); end
            end
        end
        pwren = 1'b0;
        kwren = 1'b0;
        rden  = 1'b0;
        n_tests++; if (npop !== 4) begin n_fail++; $display("FAIL b2b_pop_count got %0d want 4", npop); end
        n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL b2b_empty got %b want 1", empty); end
        n_tests++; if (pfull !== 1'b0) begin n_fail++; $display("FAIL b2b_patch_full got %b want 0", pfull); end
        n_tests++; if (kfull !== 1'b0) begin n_fail++; $display("FAIL b2b_kernel_idle got %b want 0", kfull); end
    endtask

    task automatic test_async_reset();
        write_patch(32'h0001_0000, 32'h0001_0000);
        #3;
        rst_n = 1'b0;
        #1;
        n_tests++; if (kfull !== 1'b0) begin n_fail++; $display("FAIL areset_kernel_full got %b want 0", kfull); end
        n_tests++; if (pfull !== 1'b1) begin n_fail++; $display("FAIL areset_patch_full got %b want 1", pfull); end
        n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL areset_empty got %b want 1", empty); end
        n_tests++; if (eof !== 1'b0) begin n_fail++; $display("FAIL areset_eof got %b want 0", eof); end
        n_tests++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL areset_data got %h want 00000000", rdata); end
        #2;
        rst_n = 1'b1;
        repeat (6) tick();
        n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL areset_no_push got empty=%b want 1", empty); end
        n_tests++; if (pfull !== 1'b1) begin n_fail++; $display("FAIL areset_kernel_lost got %b want 1", pfull); end
    endtask

    initial begin
        rst_n = 1'b0;
        kdata = '0;
        kwren = 1'b0;
        kopen = 1'b1;
        pdata = '0;
        pwren = 1'b0;
        popen = 1'b1;
        rden  = 1'b0;
        ropen = 1'b1;
        test_reset();
        test_basic();
        test_backpressure();
        test_overflow();
        test_abort_eof();
        test_back_to_back();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/patch_mac_endpoint.md
# patch_mac_endpoint

User-side endpoint for the Xillybus core's 32-bit streams in the SRCNN patch multiplier. It loads a kernel from the `write_kernel_32` stream and consumes patch words from the `write_patch_32` stream. Each patch is dot-multiplied with the kernel in a 3-stage pipeline. One 32-bit fixed-point result per patch is queued for the host on the `read_32` stream.

## Interface
Parameters:
- `KLEN`, default 9: words per kernel and per patch; valid range 2..256.
- `FRAC_BITS`, default 16: fractional bits of the Q-format, applied to both inputs and the output.
- `OUT_DEPTH`, default 16: result FIFO depth; power of 2, at least 2.

Ports:
- `bus_clk` in 1: single clock.
- `bus_rst_n` in 1: reset, asynchronous, active-low.
- `user_w_write_kernel_32_data` in 32: kernel word, signed.
- `user_w_write_kernel_32_wren` in 1: kernel word strobe.
- `user_w_write_kernel_32_full` out 1: kernel stream backpressure.
- `user_w_write_kernel_32_open` in 1: kernel file open.
- `user_w_write_patch_32_data` in 32: patch word, signed.
- `user_w_write_patch_32_wren` in 1: patch word strobe.
- `user_w_write_patch_32_full` out 1: patch stream backpressure.
- `user_w_write_patch_32_open` in 1: patch file open.
- `user_r_read_32_rden` in 1: result pop request.
- `user_r_read_32_data` out 32: result word.
- `user_r_read_32_empty` out 1: result FIFO empty.
- `user_r_read_32_eof` out 1: end of result stream.
- `user_r_read_32_open` in 1: read file open.

## Operation
**Kernel stream**
- Kernel RAM has `KLEN`×32 entries with write index `kidx`.
- Each accepted word is written to `kidx`; `kidx` then wraps from `KLEN-1` to 0.
- `kloaded` is set when `kidx` wraps. After that it stays set until reset; a new kernel overwrites the old one in place.
- `kernel_full` = 1 while `pidx≠0` or the pipeline is non-empty, so the kernel never changes mid-patch.

**Patch stream**
- A patch word is accepted when `wren` is high and `patch_full` is low. `wren` while full is ignored.
- `patch_full` = `!kloaded || reserved==OUT_DEPTH`.
- `reserved` = (results in FIFO) + (results in flight). It is incremented when the last word of a patch (`pidx==KLEN-1`) is accepted, and decremented on pop.
- Pipeline stages:
  - S1 registers `{patch, kram[pidx], first, last}`.
  - S2 computes the signed 32×32 product, 64 bits wide.
  - S3 accumulates in 72 bits; `first` loads the accumulator instead of adding.
- When S3 holds `last`, the result is pushed. It is computed as `acc >>> FRAC_BITS` (arithmetic shift), then narrowed to 32 bits according to the Configuration section.

**Read stream**
- The read side behaves as a standard FIFO, not first-word-fall-through.
- `rden` with `empty`=0 pops. `data` is registered and valid the cycle after `rden`; it holds its value otherwise.
- `rden` while empty is ignored.
- `eof` is set when all of the following hold: `patch_open` is 0, `pidx`=0, pipeline empty, FIFO empty. While set, `empty` stays 1.
- `eof` clears when `patch_open` rises.

**Close and flush**
- Falling `patch_open` mid-patch discards the partial patch: `pidx`←0, in-flight non-last words are dropped, and `reserved` is unchanged.
- Falling `read_open` flushes the FIFO and subtracts the flushed count from `reserved`.

**Reset** (asynchronous, `bus_rst_n`=0)
- Outputs: `kernel_full`=0, `patch_full`=1, `empty`=1, `eof`=0, `data`=0.
- State: `kidx`=`pidx`=0, `kloaded`=0, pipeline valid bits cleared, FIFO empty, `reserved`=0.
- Reset mid-patch loses all state; the kernel must be reloaded.

## Timing
- Patch and kernel words are accepted at one word per cycle, with no bubbles.
- Last patch word accepted at edge T → result pushed at T+3; `empty` goes low from T+3.
- `rden` at edge R → `data` valid after R+1.
- `full` outputs are registered-equivalent: they depend on state only, never on same-cycle `wren`.
- A push and a pop in the same cycle: FIFO count is unchanged. `reserved` is then incremented by a same-cycle last-word accept and decremented by the pop independently, with no lost update.
- FIFO full cannot occur, because `reserved` gates acceptance. FIFO pointers wrap modulo `OUT_DEPTH`.

## Configuration
- `PATCH_MAC_SATURATE_EN` defined: the narrowing to 32 bits saturates to 0x7FFFFFFF / 0x80000000.
- `PATCH_MAC_SATURATE_EN` undefined: the narrowing keeps the low 32 bits, two's-complement wrap.

## Test plan
- **Basic dot product.** KLEN=9, FRAC_BITS=16. Kernel of nine 0x00010000 (1.0), patch 1..9 in Q16.16 → one result 0x002D0000 (45.0), with `empty` falling 3 cycles after the last write.
- **Backpressure.** Before any kernel, `patch_full`=1 and patch writes are ignored. With OUT_DEPTH=16 and no reads, 16 patches are accepted. `patch_full`=1 during the 17th patch's first word until one `rden`, after which it drops and all 17 results are read in order.
- **Overflow.** Kernel all 0x7FFFFFFF, patch all 0x7FFFFFFF → 0x7FFFFFFF with `PATCH_MAC_SATURATE_EN`; the low 32 bits of `(9·(2^31−1)^2)>>>16` without it.
- **Abort and EOF.** Write 4 patch words, drop `patch_open` → no result, `pidx`=0. `eof`=1 once the FIFO drains; reopening clears `eof`.
- **Concurrent traffic.** Back-to-back patches with `rden` every cycle, including a push and pop in the same cycle. The FIFO count stays consistent, there are no duplicate or lost results, and the kernel write is held off (`kernel_full`=1) mid-patch.
- **Async reset.** Async reset mid-pipeline → all outputs at reset values within the same cycle, no push after reset release.
